dec_onehot_scan: RTL and testbench

- Registered, parametrised N-to-2^N binary-to-one-hot decoder with enable; successor to the combinational 2x4/4x16 decoders.
- Adds direct decode, hold, and automatic up/down scan modes, with a programmable dwell per output.
- Drives strobe/select fan-outs such as display digit scan, bank select and round-robin channel enables.

---
 rtl/dec_onehot_scan.sv | 106 ++++++++++
 tb/tb_dec_onehot_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dec_onehot_scan.sv
// Registered N-to-2^N one-hot decoder with hold, direct and up/down scan modes.
// Scan modes step the decoded index every DWELL enabled clocks and pulse wrap on rollover.
module dec_onehot_scan #(
    parameter int N     = 4,
    parameter int DWELL = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       i,
    input  logic               load,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       idx,
    output logic               valid,
    output logic               wrap
);

    localparam int W  = 2 ** N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [W-1:0]  ONE_HOT0 = W'(1);

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        DIRECT    = 2'b01,
        SCAN_UP   = 2'b10,
        SCAN_DOWN = 2'b11
    } mode_e;

    mode_e         mode_cur;
    mode_e         prev_mode_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic [N-1:0]  idx_next;
    logic          wrap_next;
    logic          restart;

    assign mode_cur = mode_e'(mode);

    // A mode change or the first cycle after being disabled restarts the dwell
    // without stepping, so every scan position gets a full DWELL.
    assign restart = (mode_cur != prev_mode_q) || !valid;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        idx_next  = idx;
        cnt_next  = cnt_q;
        wrap_next = 1'b0;
        case (mode_cur)
            DIRECT: begin
                idx_next = i;
                cnt_next = '0;
            end
            HOLD: begin
                if (restart) cnt_next = '0;
            end
            SCAN_UP, SCAN_DOWN: begin
                if (load) begin
                    idx_next = i;
                    cnt_next = '0;
                end else if (restart) begin
                    cnt_next = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_next = '0;
                    if (mode_cur == SCAN_UP) begin
                        idx_next  = idx + N'(1);
                        wrap_next = (idx == '1);
                    end else begin
                        idx_next  = idx - N'(1);
                        wrap_next = (idx == '0);
                    end
                end else begin
                    cnt_next = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y           <= '0;
            idx         <= '0;
            valid       <= 1'b0;
            wrap        <= 1'b0;
            cnt_q       <= '0;
            prev_mode_q <= HOLD;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            prev_mode_q <= mode_cur;
            if (!en) begin
                y     <= '0;
                valid <= 1'b0;
                wrap  <= 1'b0;
                cnt_q <= '0;
            end else begin
                y     <= ONE_HOT0 << idx_next;
                idx   <= idx_next;
                valid <= 1'b1;
                wrap  <= wrap_next;
                cnt_q <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Directed table-driven bench for dec_onehot_scan plus DWELL=1, async reset and
// randomised invariant checks on N=3 and N=5 instances.
module tb_dec_onehot_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [4:0] i_bus = '0;
    logic       load = 1'b0;

    logic [15:0] y_m;   logic [3:0] idx_m;  logic valid_m;  logic wrap_m;
    logic [15:0] y_d1;  logic [3:0] idx_d1; logic valid_d1; logic wrap_d1;
    logic [7:0]  y_n3;  logic [2:0] idx_n3; logic valid_n3; logic wrap_n3;
    logic [31:0] y_n5;  logic [4:0] idx_n5; logic valid_n5; logic wrap_n5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dec_onehot_scan #(.N(4), .DWELL(3)) u_main (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i_bus[3:0]), .load(load),
        .y(y_m), .idx(idx_m), .valid(valid_m), .wrap(wrap_m));
    dec_onehot_scan #(.N(4), .DWELL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i_bus[3:0]), .load(load),
        .y(y_d1), .idx(idx_d1), .valid(valid_d1), .wrap(wrap_d1));
    dec_onehot_scan #(.N(3), .DWELL(2)) u_n3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i_bus[2:0]), .load(load),
        .y(y_n3), .idx(idx_n3), .valid(valid_n3), .wrap(wrap_n3));
    dec_onehot_scan #(.N(5), .DWELL(3)) u_n5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i_bus), .load(load),
        .y(y_n5), .idx(idx_n5), .valid(valid_n5), .wrap(wrap_n5));

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [3:0]  i;
        logic        load;
        logic [15:0] y;
        logic [3:0]  idx;
        logic        valid;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected y is written out from the index the scenario should reach.
    function automatic void add(logic e, logic [1:0] m, logic [3:0] iv, logic ld,
                                logic [3:0] ix, logic vd, logic wr);
        vec_t v;
        logic [15:0] one16;
        one16   = 16'h0001;
        v.en    = e;   v.mode = m;  v.i = iv;  v.load = ld;
        v.idx   = ix;  v.valid = vd; v.wrap = wr;
        v.y     = vd ? (one16 << ix) : 16'h0000;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic e, input logic [1:0] m, input logic [4:0] iv, input logic ld);
        @(negedge clk);
        en = e; mode = m; i_bus = iv; load = ld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] one16;
        one16 = 16'h0001;

        // Reset and disabled state
        repeat (3) @(posedge clk);
        #1;
        check("rst_y", 32'(y_m), 32'h0);
        check("rst_idx", 32'(idx_m), 32'h0);
        check("rst_valid", 32'(valid_m), 32'h0);
        check("rst_wrap", 32'(wrap_m), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_en0_y", 32'(y_m), 32'h0);
        check("rel_en0_valid", 32'(valid_m), 32'h0);

        // DIRECT sweep then disable
        for (int k = 0; k < 16; k++) add(1, 2'b01, 4'(k), 0, 4'(k), 1, 0);
        add(0, 2'b01, 4'd0, 0, 4'd15, 0, 0);
        // SCAN_UP from 14 across the wrap
        add(1, 2'b10, 4'd14, 1, 4'd14, 1, 0);
        add(1, 2'b10, 4'd0, 0, 4'd14, 1, 0);
        add(1, 2'b10, 4'd0, 0, 4'd14, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 2'b10, 4'd0, 0, 4'd15, 1, 0);
        add(1, 2'b10, 4'd0, 0, 4'd0, 1, 1);
        add(1, 2'b10, 4'd0, 0, 4'd0, 1, 0);
        // SCAN_DOWN from 1, wrap 0->15, load on the due step
        add(1, 2'b11, 4'd1, 1, 4'd1, 1, 0);
        add(1, 2'b11, 4'd0, 0, 4'd1, 1, 0);
        add(1, 2'b11, 4'd0, 0, 4'd1, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 2'b11, 4'd0, 0, 4'd0, 1, 0);
        add(1, 2'b11, 4'd0, 0, 4'd15, 1, 1);
        add(1, 2'b11, 4'd0, 0, 4'd15, 1, 0);
        add(1, 2'b11, 4'd0, 0, 4'd15, 1, 0);
        add(1, 2'b11, 4'd9, 1, 4'd9, 1, 0);
        // HOLD keeps 9, then SCAN_UP restarts the dwell before stepping
        for (int k = 0; k < 4; k++) add(1, 2'b00, 4'd3, 1, 4'd9, 1, 0);
        for (int k = 0; k < 3; k++) add(1, 2'b10, 4'd0, 0, 4'd9, 1, 0);
        add(1, 2'b10, 4'd0, 0, 4'd10, 1, 0);
        // Disable then re-enable in HOLD re-asserts y
        add(0, 2'b10, 4'd0, 0, 4'd10, 0, 0);
        add(1, 2'b00, 4'd0, 0, 4'd10, 1, 0);
        // DIRECT ignores load
        add(1, 2'b01, 4'd3, 1, 4'd3, 1, 0);

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].mode, {1'b0, vecs[k].i}, vecs[k].load);
            check($sformatf("vec%0d_y", k), 32'(y_m), 32'(vecs[k].y));
            check($sformatf("vec%0d_idx", k), 32'(idx_m), 32'(vecs[k].idx));
            check($sformatf("vec%0d_valid", k), 32'(valid_m), 32'(vecs[k].valid));
            check($sformatf("vec%0d_wrap", k), 32'(wrap_m), 32'(vecs[k].wrap));
        end

        // DWELL=1: step every cycle, one wrap over 16 steps
        drive(1, 2'b10, 5'd0, 1);
        check("d1_load_idx", 32'(idx_d1), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            drive(1, 2'b10, 5'd0, 0);
            check($sformatf("d1_step%0d_idx", k), 32'(idx_d1), 32'(k % 16));
            check($sformatf("d1_step%0d_y", k), 32'(y_d1), 32'(one16 << (k % 16)));
            check($sformatf("d1_step%0d_wrap", k), 32'(wrap_d1), 32'(k == 16));
        end
        drive(1, 2'b10, 5'd0, 0);
        drive(1, 2'b10, 5'd0, 0);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_y", 32'(y_d1), 32'h0);
        check("async_valid", 32'(valid_d1), 32'h0);
        check("async_idx", 32'(idx_d1), 32'h0);
        check("async_main_y", 32'(y_m), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idx", 32'(idx_d1), 32'h0);
        check("post_rst_y", 32'(y_d1), 32'h1);
        check("post_rst_valid", 32'(valid_d1), 32'h1);
        drive(1, 2'b10, 5'd0, 0);
        check("post_rst_step_idx", 32'(idx_d1), 32'h1);

        // Randomised invariants on N=3 and N=5
        for (int k = 0; k < 400; k++) begin
            logic       e;
            logic [1:0] m;
            logic       ld;
            logic [7:0] one8;
            logic [31:0] one32;
            one8  = 8'h01;
            one32 = 32'h1;
            e  = ($urandom_range(9) != 0);
            m  = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : mode;
            ld = ($urandom_range(15) == 0);
            drive(e, m, 5'($urandom), ld);
            check("n3_y", 32'(y_n3), valid_n3 ? 32'(one8 << idx_n3) : 32'h0);
            check("n5_y", y_n5, valid_n5 ? (one32 << idx_n5) : 32'h0);
            check("n3_wrap_valid", 32'(wrap_n3 & ~valid_n3), 32'h0);
            check("n5_wrap_valid", 32'(wrap_n5 & ~valid_n5), 32'h0);
            check("n3_valid_en", 32'(valid_n3), 32'(e));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
